// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr selectable-mode stream multiplexer.
// Holds the mode encoding and the packed in_data slice convention.
package stream_mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel ch occupies bits [ch*width +: width] of the packed input bus.
  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin search: rotate requests so the channel after
// 'last' sits at bit 0, priority-encode, then map the winner back.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [N_CH-1:0] rot;
  int              start;
  int              off;
  logic            found;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    rot       = '0;
    off       = 0;
    found     = 1'b0;
    start     = (int'(last) + 1) % N_CH;
    for (int j = 0; j < N_CH; j++) begin
      rot[j] = req[(start + j) % N_CH];
    end
    for (int j = 0; j < N_CH; j++) begin
      if (rot[j] && !found) begin
        found = 1'b1;
        off   = j;
      end
    end
    gnt_valid = found;
    gnt_idx   = SEL_W'((start + off) % N_CH);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with run-time fixed-select or
// round-robin arbitration and a single registered output stage.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_ok;
  logic [WIDTH-1:0] sel_word;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .last      (last_grant),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // The output slot can take a new word when empty or when it drains this cycle.
  assign load_ok = !out_valid || out_ready;

  always_comb begin
    grant       = sel;
    grant_valid = 1'b0;
    if (mode == MODE_RR) begin
      grant       = rr_idx;
      grant_valid = rr_valid;
    end else begin
      // A sel value outside 0..N_CH-1 matches nothing and grants nobody.
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i)) grant_valid = in_valid[i];
      end
    end
    sel_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) sel_word = in_data[slice_lo(i, WIDTH) +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = load_ok && grant_valid && (grant == SEL_W'(i)) && !rst;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N_CH - 1);
    end else if (load_ok && grant_valid) begin
      out_data   <= sel_word;
      out_ch     <= grant;
      out_valid  <= 1'b1;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, then random
// stimulus compared against a behavioural model of the selection rules.
module tb_stream_mux_rr;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  int n_pass  = 0;
  int n_total = 0;

  stream_mux_rr #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   iv;
    logic [N*W-1:0] id;
    logic           ordy;
    logic [N-1:0]   exp_rdy;
    logic           exp_ov;
    logic [W-1:0]   exp_od;
    logic [SW-1:0]  exp_och;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic [SW-1:0] s,
                     input logic [N-1:0] iv, input logic [N*W-1:0] id, input logic ordy,
                     input logic [N-1:0] er, input logic eov, input logic [W-1:0] eod,
                     input logic [SW-1:0] eoch);
    vec_t v;
    v.rst = r; v.mode = m; v.sel = s; v.iv = iv; v.id = id; v.ordy = ordy;
    v.exp_rdy = er; v.exp_ov = eov; v.exp_od = eod; v.exp_och = eoch;
    vecs.push_back(v);
  endtask

  // Drive one cycle: set inputs, check combinational in_ready, clock, check outputs.
  task automatic apply(input string tag, input vec_t v);
    rst = v.rst; mode = v.mode; sel = v.sel; in_valid = v.iv;
    in_data = v.id; out_ready = v.ordy;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
    @(posedge clk); #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    check({tag, " out_data"}, 32'(out_data), 32'(v.exp_od));
    check({tag, " out_ch"}, 32'(out_ch), 32'(v.exp_och));
  endtask

  // Reference model state: contents of the output slot and the last grant.
  logic          m_valid;
  logic [W-1:0]  m_data;
  int            m_ch;
  int            m_last;

  initial begin
    logic [N*W-1:0] rr_data;
    int             g;
    logic           g_valid;
    logic           load;
    logic [N-1:0]   exp_rdy;
    rr_data = 16'h4321;

    // reset with everything requesting
    add(1, 1, 0, 4'hF, rr_data, 1, 4'h0, 0, 4'h0, 0);
    add(1, 1, 0, 4'hF, rr_data, 1, 4'h0, 0, 4'h0, 0);
    // fixed select of channel 2 while channel 0 also requests
    add(0, 0, 2, 4'b0101, 16'h0A05, 1, 4'b0100, 1, 4'hA, 2);
    add(0, 0, 2, 4'b0101, 16'h0A05, 1, 4'b0100, 1, 4'hA, 2);
    add(0, 0, 2, 4'b0000, 16'h0A05, 1, 4'b0000, 0, 4'hA, 2);
    // reset restarts the round-robin pointer, then saturated round-robin
    add(1, 1, 0, 4'hF, rr_data, 1, 4'h0, 0, 4'h0, 0);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0010, 1, 4'h2, 1);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0100, 1, 4'h3, 2);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b1000, 1, 4'h4, 3);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0010, 1, 4'h2, 1);
    // backpressure freezes the held word, release grants channel 2
    add(0, 1, 0, 4'hF, rr_data, 0, 4'h0, 1, 4'h2, 1);
    add(0, 1, 0, 4'hF, rr_data, 0, 4'h0, 1, 4'h2, 1);
    add(0, 1, 0, 4'hF, rr_data, 0, 4'h0, 1, 4'h2, 1);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0100, 1, 4'h3, 2);
    // sparse round-robin alternates 3,1,3,1
    add(0, 1, 0, 4'b1010, rr_data, 1, 4'b1000, 1, 4'h4, 3);
    add(0, 1, 0, 4'b1010, rr_data, 1, 4'b0010, 1, 4'h2, 1);
    add(0, 1, 0, 4'b1010, rr_data, 1, 4'b1000, 1, 4'h4, 3);
    add(0, 1, 0, 4'b1010, rr_data, 1, 4'b0010, 1, 4'h2, 1);
    // reset while a word is held under backpressure
    add(0, 1, 0, 4'hF, rr_data, 0, 4'h0, 1, 4'h2, 1);
    add(1, 1, 0, 4'hF, rr_data, 0, 4'h0, 0, 4'h0, 0);
    add(0, 1, 0, 4'hF, rr_data, 1, 4'b0001, 1, 4'h1, 0);

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Random phase: start from a known reset so the model and DUT agree.
    apply("rnd_reset", '{1, 1, 0, 4'h0, '0, 1, 4'h0, 0, 4'h0, 0});
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 63) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);

      g = 0;
      g_valid = 1'b0;
      if (mode == 1'b0) begin
        g = int'(sel);
        g_valid = in_valid[g];
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!g_valid && in_valid[(m_last + k) % N]) begin
            g = (m_last + k) % N;
            g_valid = 1'b1;
          end
        end
      end
      load = !m_valid || out_ready;
      exp_rdy = (load && g_valid && !rst) ? N'(1 << g) : '0;

      #1;
      check("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk); #1;

      if (rst) begin
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;
      end else if (load && g_valid) begin
        m_valid = 1'b1;
        m_data  = W'(in_data >> (g * W));
        m_ch    = g;
        m_last  = g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end

      check("rnd out_valid", 32'(out_valid), 32'(m_valid));
      check("rnd out_data", 32'(out_data), 32'(m_data));
      check("rnd out_ch", 32'(out_ch), 32'(m_ch));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
